// File: rtl/vowel_pkg.sv
// Shared definitions for the vowel eliminator: character type, the vowel
// codes, and the default fill code for vacated output slots.
package vowel_pkg;

  typedef logic [7:0] char_t;

  localparam char_t VOWEL_UC_A = 8'h41;
  localparam char_t VOWEL_UC_E = 8'h45;
  localparam char_t VOWEL_UC_I = 8'h49;
  localparam char_t VOWEL_UC_O = 8'h4F;
  localparam char_t VOWEL_UC_U = 8'h55;
  localparam char_t VOWEL_UC_Y = 8'h59;
  localparam char_t VOWEL_LC_A = 8'h61;
  localparam char_t VOWEL_LC_E = 8'h65;
  localparam char_t VOWEL_LC_I = 8'h69;
  localparam char_t VOWEL_LC_O = 8'h6F;
  localparam char_t VOWEL_LC_U = 8'h75;
  localparam char_t VOWEL_LC_Y = 8'h79;

  localparam char_t FILL_CHAR_DEF = 8'h00;

endpackage

// File: rtl/vowel_detect.sv
// Combinational single-character vowel classifier.
// Optional macro VOWEL_Y_EN: when defined, 'Y' and 'y' also count as vowels.
module vowel_detect
  import vowel_pkg::*;
(
  input  char_t i_char,
  output logic  o_is_vowel
);

  // Match the character against the fixed vowel code set
  always_comb begin
    o_is_vowel = 1'b0;
    case (i_char)
      VOWEL_UC_A, VOWEL_UC_E, VOWEL_UC_I, VOWEL_UC_O, VOWEL_UC_U,
      VOWEL_LC_A, VOWEL_LC_E, VOWEL_LC_I, VOWEL_LC_O, VOWEL_LC_U:
        o_is_vowel = 1'b1;
`ifdef VOWEL_Y_EN
      VOWEL_UC_Y, VOWEL_LC_Y:
        o_is_vowel = 1'b1;
`else
`endif
      default: o_is_vowel = 1'b0;
    endcase
  end

endmodule

// File: rtl/vowel_eliminator.sv
// Vowel eliminator: classifies every character of a word, packs the
// non-vowels toward char 0 in their original order, pads the tail with
// FILL_CHAR and registers result, vowel mask and kept count (latency 1).
// Optional macro VOWEL_Y_EN (handled in vowel_detect): treat Y/y as vowels.
module vowel_eliminator
  import vowel_pkg::*;
#(
  parameter int    N_CHARS   = 8,
  parameter char_t FILL_CHAR = FILL_CHAR_DEF
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [8*N_CHARS-1:0]         list_i,
  output logic                         out_valid,
  output logic [8*N_CHARS-1:0]         res_o,
  output logic [N_CHARS-1:0]           is_vowel_o,
  output logic [$clog2(N_CHARS+1)-1:0] keep_cnt_o
);

  localparam int CW = $clog2(N_CHARS+1);

  logic [N_CHARS-1:0]   w_vowel;
  logic [CW-1:0]        w_pos [N_CHARS];
  logic [CW-1:0]        w_keep;
  logic [8*N_CHARS-1:0] w_res;

  logic                 r_valid;
  logic [8*N_CHARS-1:0] r_res;
  logic [N_CHARS-1:0]   r_mask;
  logic [CW-1:0]        r_cnt;

  // One classifier per character position
  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_det
    vowel_detect u_det (
      .i_char     (list_i[8*gi +: 8]),
      .o_is_vowel (w_vowel[gi])
    );
  end

  // Exclusive prefix count of kept chars: destination slot of each kept char
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < N_CHARS; i++) begin
      w_pos[i] = w_keep;
      if (!w_vowel[i]) w_keep = w_keep + CW'(1);
    end
  end

  // Each output slot selects the unique kept char whose destination matches
  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_slot
    char_t w_slot;
    always_comb begin
      w_slot = FILL_CHAR;
      for (int i = 0; i < N_CHARS; i++) begin
        if (!w_vowel[i] && (int'(w_pos[i]) == gi)) w_slot = list_i[8*i +: 8];
      end
    end
    assign w_res[8*gi +: 8] = w_slot;
  end

  // Register results on accepted words; data holds while input is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= {N_CHARS{FILL_CHAR}};
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_res  <= w_res;
        r_mask <= w_vowel;
        r_cnt  <= w_keep;
      end
    end
  end

  assign out_valid  = r_valid;
  assign res_o      = r_res;
  assign is_vowel_o = r_mask;
  assign keep_cnt_o = r_cnt;

endmodule

// File: tb/tb_vowel_eliminator.sv
// Scoreboard bench for vowel_eliminator: a driver issues directed and random
// words and queues the reference result; a monitor checks every cycle.
module tb_vowel_eliminator;

  typedef struct {
    logic [63:0] res;
    logic [7:0]  mask;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] list_i;
  logic        out_valid;
  logic [63:0] res_o;
  logic [7:0]  is_vowel_o;
  logic [3:0]  keep_cnt_o;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t last;

  vowel_eliminator dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .list_i     (list_i),
    .out_valid  (out_valid),
    .res_o      (res_o),
    .is_vowel_o (is_vowel_o),
    .keep_cnt_o (keep_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: a character is a vowel if it appears in the vowel string
  function automatic bit ref_is_vowel(input logic [7:0] c);
    string vs;
`ifdef VOWEL_Y_EN
    vs = "AEIOUaeiouYy";
`else
    vs = "AEIOUaeiou";
`endif
    for (int k = 0; k < vs.len(); k++)
      if (vs[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: filter kept chars into a list, then lay them out from slot 0
  function automatic exp_t model(input logic [63:0] w);
    exp_t        e;
    logic [7:0]  kept[$];
    logic [7:0]  c;
    e.mask = '0;
    for (int i = 0; i < 8; i++) begin
      c = w[8*i +: 8];
      if (ref_is_vowel(c)) e.mask[i] = 1'b1;
      else kept.push_back(c);
    end
    e.res = '0;
    for (int k = 0; k < kept.size(); k++) e.res[8*k +: 8] = kept[k];
    e.cnt = 4'(kept.size());
    return e;
  endfunction

  function automatic logic [63:0] str2word(input string s);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = s[i];
    return w;
  endfunction

  function automatic logic [63:0] rand_word();
    string       pool = "AEIOUaeiouYyBCDFGHJKLMNPQRSTVWXZbcdfghklmnpqrstvwxz09 !";
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(3) != 0) w[8*i +: 8] = pool[$urandom_range(pool.len()-1)];
      else                        w[8*i +: 8] = 8'($urandom_range(255));
    end
    return w;
  endfunction

  task automatic send(input logic [63:0] w, input bit v);
    @(negedge clk);
    list_i   = w;
    in_valid = v;
    if (v) begin
      q.push_back(model(w));
      $display("issue word=%h", w);
    end
  endtask

  // Monitor: one check set per cycle, just after the active edge
  initial begin
    exp_t e;
    bit   exp_v;
    last.res = '0; last.mask = '0; last.cnt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        q.delete();
        last.res = '0; last.mask = '0; last.cnt = '0;
      end else begin
        exp_v = (q.size() > 0);
        check("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
          e = q.pop_front();
          check("res_o", res_o, e.res);
          check("is_vowel_o", 64'(is_vowel_o), 64'(e.mask));
          check("keep_cnt_o", 64'(keep_cnt_o), 64'(e.cnt));
          last = e;
          $display("result res=%h mask=%h cnt=%0d", res_o, is_vowel_o, keep_cnt_o);
        end else begin
          check("hold_res", res_o, last.res);
          check("hold_mask", 64'(is_vowel_o), 64'(last.mask));
          check("hold_cnt", 64'(keep_cnt_o), 64'(last.cnt));
        end
      end
    end
  end

  // Driver and directed sequence
  initial begin
    rst = 1'b1; in_valid = 1'b0; list_i = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", res_o, 64'd0);
    check("rst_mask", 64'(is_vowel_o), 64'd0);
    check("rst_cnt", 64'(keep_cnt_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    send(str2word("BCDFGHJK"), 1'b1);
    send(str2word("AEIOUaei"), 1'b1);
    send(str2word("HELLOWRD"), 1'b1);
    send(str2word("XYZYQBAY"), 1'b1);
    for (int i = 0; i < 3; i++) send(rand_word(), 1'b0);

    for (int i = 0; i < 200; i++) send(rand_word(), $urandom_range(3) != 0);
    send(rand_word(), 1'b0);

    // Reset in the middle of a stream with a word still being presented
    send(rand_word(), 1'b1);
    send(rand_word(), 1'b1);
    @(negedge clk);
    list_i   = rand_word();
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_res", res_o, 64'd0);
    check("midrst_mask", 64'(is_vowel_o), 64'd0);
    check("midrst_cnt", 64'(keep_cnt_o), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    for (int i = 0; i < 60; i++) send(rand_word(), $urandom_range(1) != 0);
    for (int i = 0; i < 3; i++) send(rand_word(), 1'b0);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
